// File: rtl/shift_add_mul_sequencer.sv
// Serial-operand 4x4 shift-add multiplier sequencer with optional MAC accumulation.
// io_out shows either the result register or a packed status word.
module shift_add_mul_sequencer #(
  parameter bit ACCUMULATE = 1'b0
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int unsigned NIB_W = 4;
  localparam int unsigned RES_W = 8;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GOT_A  = 2'b01,
    BUSY   = 2'b10,
    UNUSED = 2'b11
  } state_e;

  logic             clk;
  logic             rst;
  logic             stb;
  logic             view;
  logic [NIB_W-1:0] nibble;

  assign clk    = io_in[0];
  assign rst    = io_in[1];
  assign stb    = io_in[2];
  assign view   = io_in[3];
  assign nibble = io_in[7:4];

  state_e           state_q, state_d;
  logic [NIB_W-1:0] a_q, a_d;
  logic [NIB_W-1:0] b_q, b_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             overrun_q, overrun_d;
  logic             rvalid_q, rvalid_d;
  logic [CNT_W-1:0] ops_q, ops_d;

  logic [RES_W-1:0] addend;
  logic [RES_W-1:0] acc_sum;

  // One partial product per BUSY cycle, selected by the current multiplier bit.
  assign addend  = b_q[cnt_q] ? (RES_W'(a_q) << cnt_q) : RES_W'(0);
  assign acc_sum = acc_q + addend;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    overrun_d = overrun_q;
    rvalid_d  = rvalid_q;
    ops_d     = ops_q;

    case (state_q)
      GOT_A: begin
        if (stb) begin
          b_d     = nibble;
          acc_d   = RES_W'(0);
          cnt_d   = CNT_W'(0);
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(1);
        // A strobe during BUSY, including the last edge, is dropped and flagged.
        if (stb) begin
          overrun_d = 1'b1;
        end
        if (cnt_q == CNT_W'(3)) begin
          result_d = ACCUMULATE ? (result_q + acc_sum) : acc_sum;
          rvalid_d = 1'b1;
          ops_d    = ops_q + CNT_W'(1);
          state_d  = IDLE;
        end
      end
      default: begin
        if (stb) begin
          a_d     = nibble;
          state_d = GOT_A;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      overrun_q <= 1'b0;
      rvalid_q  <= 1'b0;
      ops_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      overrun_q <= overrun_d;
      rvalid_q  <= rvalid_d;
      ops_q     <= ops_d;
    end
  end

  assign io_out = view ? {state_q, overrun_q, rvalid_q, cnt_q, ops_q} : result_q;

endmodule
